vend_ctrl: RTL

- Sequencing controller for the vending machine datapath.
- Accepts coins and accumulates credit, then accepts a vend request and pulses the dispense strobe.
- Returns change one coin per cycle; the largest coin that fits is returned first.
- Sits between the coin-acceptor decode logic and the combinational product/selection decode.

---
 rtl/vend_ctrl.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/vend_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : vend_ctrl
//  Description : Sequencing controller for the vending machine datapath.
//                Accumulates coin credit, vends on request once the credit
//                covers PRICE, then pays change one coin per cycle, always
//                returning the largest coin that fits first.
//  Optional    : `define VEND_CANCEL_EN adds a `cancel` input that refunds the
//                full credit through the change sequence (no dispense).
//  Ports       :
//    clk          in   system clock, rising edge
//    rst_n        in   asynchronous active-low reset
//    coin_valid   in   one-cycle strobe, coin presented on coin_type
//    coin_type    in   00 nickel, 01 dime, 10 quarter, 11 invalid
//    sel          in   vend request (level or pulse)
//    cancel       in   refund request (only with VEND_CANCEL_EN)
//    credit       out  current credit in cents
//    dispense     out  one-cycle dispense strobe
//    change_valid out  a change coin is emitted this cycle
//    change_coin  out  code of the emitted change coin
//    coin_reject  out  one-cycle strobe, last presented coin is returned
//    busy         out  high while dispensing or paying change
//  Revision    : 1.0  initial release
// ============================================================================
module vend_ctrl #(
    parameter int PRICE      = 75,
    parameter int MAX_CREDIT = 200,
    parameter int CREDIT_W   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin_valid,
    input  logic [1:0]          coin_type,
    input  logic                sel,
`ifdef VEND_CANCEL_EN
    input  logic                cancel,
`endif
    output logic [CREDIT_W-1:0] credit,
    output logic                dispense,
    output logic                change_valid,
    output logic [1:0]          change_coin,
    output logic                coin_reject,
    output logic                busy
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0] c_NICKEL  = 2'b00;
    localparam logic [1:0] c_DIME    = 2'b01;
    localparam logic [1:0] c_QUARTER = 2'b10;
    localparam logic [1:0] c_INVALID = 2'b11;

    localparam logic [CREDIT_W-1:0] c_PRICE   = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W:0]   c_MAX     = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] c_CENTS_N = CREDIT_W'(5);
    localparam logic [CREDIT_W-1:0] c_CENTS_D = CREDIT_W'(10);
    localparam logic [CREDIT_W-1:0] c_CENTS_Q = CREDIT_W'(25);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_COLLECT  = 2'd1,
        S_DISPENSE = 2'd2,
        S_CHANGE   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    // Value of a coin code in cents; the invalid code is worth nothing.
    function automatic logic [CREDIT_W-1:0] coin_cents(input logic [1:0] code);
        logic [CREDIT_W-1:0] cents;
        case (code)
            c_NICKEL:  cents = c_CENTS_N;
            c_DIME:    cents = c_CENTS_D;
            c_QUARTER: cents = c_CENTS_Q;
            default:   cents = '0;
        endcase
        return cents;
    endfunction

    // Largest coin not exceeding the amount still owed.
    function automatic logic [1:0] pick_coin(input logic [CREDIT_W-1:0] amt);
        logic [1:0] code;
        if (amt >= c_CENTS_Q) begin
            code = c_QUARTER;
        end else if (amt >= c_CENTS_D) begin
            code = c_DIME;
        end else begin
            code = c_NICKEL;
        end
        return code;
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t              r_state;
    logic [CREDIT_W-1:0] r_credit;
    logic                r_dispense;
    logic                r_change_valid;
    logic [1:0]          r_change_coin;
    logic                r_coin_reject;
    logic                r_busy;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                w_coin_good;
    logic [CREDIT_W-1:0] w_coin_cents;
    logic [CREDIT_W:0]   w_sum;
    logic                w_fits;
    logic                w_vend;
    logic                w_cancel;
    logic [CREDIT_W-1:0] w_remain;
    logic [CREDIT_W-1:0] w_chg_left;

    assign w_coin_good  = (coin_type != c_INVALID);
    assign w_coin_cents = coin_cents(coin_type);
    // One extra bit so the overflow guard sees the true sum.
    assign w_sum        = {1'b0, r_credit} + {1'b0, w_coin_cents};
    assign w_fits       = (w_sum <= c_MAX);
    assign w_vend       = sel && (r_credit >= c_PRICE);
    assign w_remain     = r_credit - c_PRICE;
    // r_change_coin holds the coin being paid out this cycle.
    assign w_chg_left   = r_credit - coin_cents(r_change_coin);

`ifdef VEND_CANCEL_EN
    assign w_cancel = cancel && (r_credit != '0);
`else
    assign w_cancel = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Controller. Outputs are registered and are loaded on the edge that
    // enters the state they belong to, so they line up with r_state.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_credit       <= '0;
            r_dispense     <= 1'b0;
            r_change_valid <= 1'b0;
            r_change_coin  <= c_NICKEL;
            r_coin_reject  <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            // Pulse outputs fall back to zero unless re-armed below.
            r_dispense     <= 1'b0;
            r_change_valid <= 1'b0;
            r_change_coin  <= c_NICKEL;
            r_coin_reject  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_busy <= 1'b0;
                    if (coin_valid) begin
                        if (w_coin_good) begin
                            r_credit <= w_coin_cents;
                            r_state  <= S_COLLECT;
                        end else begin
                            r_coin_reject <= 1'b1;
                        end
                    end
                end

                S_COLLECT: begin
                    if (w_cancel) begin
                        // Refund: pay the whole credit back as change.
                        r_state        <= S_CHANGE;
                        r_busy         <= 1'b1;
                        r_change_valid <= 1'b1;
                        r_change_coin  <= pick_coin(r_credit);
                        r_coin_reject  <= coin_valid;
                    end else if (w_vend) begin
                        // A coin arriving with the vend is not credited;
                        // the vend uses the credit already held.
                        r_state       <= S_DISPENSE;
                        r_busy        <= 1'b1;
                        r_dispense    <= 1'b1;
                        r_coin_reject <= coin_valid;
                    end else if (coin_valid) begin
                        if (w_coin_good && w_fits) begin
                            r_credit <= w_sum[CREDIT_W-1:0];
                        end else begin
                            r_coin_reject <= 1'b1;
                        end
                    end
                end

                S_DISPENSE: begin
                    r_credit      <= w_remain;
                    r_coin_reject <= coin_valid;
                    if (w_remain != '0) begin
                        r_state        <= S_CHANGE;
                        r_change_valid <= 1'b1;
                        r_change_coin  <= pick_coin(w_remain);
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                S_CHANGE: begin
                    r_credit      <= w_chg_left;
                    r_coin_reject <= coin_valid;
                    if (w_chg_left != '0) begin
                        r_change_valid <= 1'b1;
                        r_change_coin  <= pick_coin(w_chg_left);
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state  <= S_IDLE;
                    r_credit <= '0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign credit       = r_credit;
    assign dispense     = r_dispense;
    assign change_valid = r_change_valid;
    assign change_coin  = r_change_coin;
    assign coin_reject  = r_coin_reject;
    assign busy         = r_busy;

endmodule
`default_nettype wire
